warp_done_tracker: RTL and testbench

- Consumes the registered initial done-mask produced by the warp-count LUT stage and tracks per-warp completion for one thread block on an SMP.
- Pre-done bits mark unused warp slots. The block ORs in completion events from the warp unit.
- Raises a one-cycle block-complete pulse once every slot is done.
- Sits between the warp-count LUT and the block scheduler's completion/retire logic.

---
 rtl/warp_done_tracker_if.sv | 34 +++
 rtl/warp_done_tracker.sv | 125 ++++++++++++
 tb/tb_warp_done_tracker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/warp_done_tracker_if.sv
// Port bundle between the block scheduler side and the per-block warp done tracker.
// All signals are qualified by clk_in of the attached tracker.
interface warp_done_tracker_if #(
   parameter int NUM_WARPS = 32,
   parameter int WARP_ID_W = 5
);
   // Handshake: there is no ready back-pressure. blk_start, wdone_valid and
   // blk_abort are single-cycle strobes that the tracker always samples on
   // the rising edge. wdone_id is meaningful only while wdone_valid is high.
   // init_mask_in must be valid in the cycle after blk_start. blk_done is a
   // one-cycle pulse that arrives together with the all-ones done_mask.
   logic                 blk_start;
   logic [NUM_WARPS-1:0] init_mask_in;
   logic                 wdone_valid;
   logic [WARP_ID_W-1:0] wdone_id;
   logic                 blk_abort;
   logic [NUM_WARPS-1:0] done_mask;
   logic [WARP_ID_W:0]   remaining;
   logic                 busy;
   logic                 blk_done;
   logic                 err_dup;
   logic                 err_spurious;
   logic [1:0]           dbg_state;

   modport master (
      output blk_start, init_mask_in, wdone_valid, wdone_id, blk_abort,
      input  done_mask, remaining, busy, blk_done, err_dup, err_spurious, dbg_state
   );

   modport slave (
      input  blk_start, init_mask_in, wdone_valid, wdone_id, blk_abort,
      output done_mask, remaining, busy, blk_done, err_dup, err_spurious, dbg_state
   );
endinterface

// File: rtl/warp_done_tracker.sv
// Tracks per-warp completion of one thread block. It loads the LUT done-mask,
// ORs in warp completion events and pulses blk_done once all slots are done.
module warp_done_tracker #(
   parameter int NUM_WARPS = 32,
   parameter int WARP_ID_W = 5
) (
   input logic                 clk_in,
   input logic                 host_reset_n,
   warp_done_tracker_if.slave  bus
);
   localparam int CNT_W = WARP_ID_W + 1;
   localparam logic [CNT_W-1:0] NUM_WARPS_C = CNT_W'(NUM_WARPS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [NUM_WARPS-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]     rem_q, rem_d;
   logic                 done_q, done_d;
   logic                 dup_q, dup_d;
   logic                 spur_q, spur_d;
   logic                 mask_we;
   logic [NUM_WARPS-1:0] onehot;

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_WARPS-1:0] m);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < NUM_WARPS; i++) cnt = cnt + CNT_W'(m[i]);
      return cnt;
   endfunction

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      done_d  = 1'b0;
      dup_d   = dup_q;
      spur_d  = spur_q;
      mask_we = 1'b0;
      onehot  = '0;
      onehot[bus.wdone_id] = 1'b1;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // A new block wins over a simultaneous stray completion event.
            if (bus.blk_start) begin
               state_d = ST_LOAD;
               dup_d   = 1'b0;
               spur_d  = 1'b0;
            end else if (bus.wdone_valid) begin
               spur_d = 1'b1;
            end
         end
         ST_LOAD: begin
            mask_we = 1'b1;
            if (bus.blk_abort) begin
               state_d = ST_IDLE;
               mask_d  = '0;
            end else begin
               mask_d = bus.init_mask_in | (bus.wdone_valid ? onehot : '0);
               if (bus.blk_start) spur_d = 1'b1;
               if (&mask_d) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (bus.blk_abort) begin
               state_d = ST_IDLE;
               mask_d  = '0;
               mask_we = 1'b1;
            end else begin
               if (bus.blk_start) spur_d = 1'b1;
               if (bus.wdone_valid) begin
                  if (mask_q[bus.wdone_id]) begin
                     dup_d = 1'b1;
                  end else begin
                     mask_d  = mask_q | onehot;
                     mask_we = 1'b1;
                  end
               end
               if (&mask_d) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // remaining only moves with a mask write, so it reads 0 out of reset.
      rem_d = mask_we ? (NUM_WARPS_C - popcount(mask_d)) : rem_q;
   end

   always_ff @(posedge clk_in) begin
      if (!host_reset_n) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         dup_q   <= 1'b0;
         spur_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         dup_q   <= dup_d;
         spur_q  <= spur_d;
      end
   end

   assign bus.done_mask    = mask_q;
   assign bus.remaining    = rem_q;
   assign bus.busy         = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign bus.blk_done     = done_q;
   assign bus.err_dup      = dup_q;
   assign bus.err_spurious = spur_q;
   assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_warp_done_tracker.sv
// Directed self-checking bench for warp_done_tracker: reset, normal, full-init,
// duplicate, abort, event-in-LOAD and back-to-back block scenarios.
module tb_warp_done_tracker;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic clk_in = 1'b0;
   logic host_reset_n;
   int   total = 0;
   int   bad   = 0;

   warp_done_tracker_if #(.NUM_WARPS(32), .WARP_ID_W(5)) bus ();

   warp_done_tracker #(.NUM_WARPS(32), .WARP_ID_W(5)) dut (
      .clk_in       (clk_in),
      .host_reset_n (host_reset_n),
      .bus          (bus.slave)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] st, input logic [31:0] mask,
                            input logic [5:0] rem, input logic busy, input logic done,
                            input logic dup, input logic spur);
      check({tag, ".state"}, 64'(bus.dbg_state), 64'(st));
      check({tag, ".mask"}, 64'(bus.done_mask), 64'(mask));
      check({tag, ".rem"}, 64'(bus.remaining), 64'(rem));
      check({tag, ".busy"}, 64'(bus.busy), 64'(busy));
      check({tag, ".done"}, 64'(bus.blk_done), 64'(done));
      check({tag, ".dup"}, 64'(bus.err_dup), 64'(dup));
      check({tag, ".spur"}, 64'(bus.err_spurious), 64'(spur));
   endtask

   task automatic idle_inputs();
      bus.blk_start    = 1'b0;
      bus.wdone_valid  = 1'b0;
      bus.wdone_id     = '0;
      bus.blk_abort    = 1'b0;
   endtask

   initial begin
      // Reset held two cycles with strobes active: reset must win.
      host_reset_n     = 1'b0;
      bus.init_mask_in = 32'hFFFF_FFFF;
      bus.blk_start    = 1'b1;
      bus.wdone_valid  = 1'b1;
      bus.wdone_id     = 5'd3;
      bus.blk_abort    = 1'b0;
      tick();
      tick();
      check_all("rst", S_IDLE, 32'h0, 6'd0, 0, 0, 0, 0);
      host_reset_n = 1'b1;
      idle_inputs();
      tick();
      check_all("rst_idle", S_IDLE, 32'h0, 6'd0, 0, 0, 0, 0);

      // Normal block: 8 free slots completed one per cycle.
      bus.blk_start = 1'b1;
      tick();
      check_all("norm_load", S_LOAD, 32'h0, 6'd0, 1, 0, 0, 0);
      bus.blk_start    = 1'b0;
      bus.init_mask_in = 32'hFFFF_FF00;
      tick();
      check_all("norm_run", S_RUN, 32'hFFFF_FF00, 6'd8, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         bus.wdone_valid = 1'b1;
         bus.wdone_id    = 5'(i);
         tick();
         check($sformatf("norm_rem%0d", i), 64'(bus.remaining), 64'(7 - i));
         check($sformatf("norm_done%0d", i), 64'(bus.blk_done), 64'(i == 7));
      end
      check_all("norm_fin", S_DONE, 32'hFFFF_FFFF, 6'd0, 0, 1, 0, 0);
      idle_inputs();
      tick();
      check_all("norm_hold", S_DONE, 32'hFFFF_FFFF, 6'd0, 0, 0, 0, 0);

      // Full-init block: completes straight out of LOAD.
      bus.blk_start = 1'b1;
      tick();
      check_all("full_load", S_LOAD, 32'hFFFF_FFFF, 6'd0, 1, 0, 0, 0);
      bus.blk_start    = 1'b0;
      bus.init_mask_in = 32'hFFFF_FFFF;
      tick();
      check_all("full_done", S_DONE, 32'hFFFF_FFFF, 6'd0, 0, 1, 0, 0);
      tick();
      check("full_pulse_end", 64'(bus.blk_done), 64'(0));

      // Duplicate completion of warp 0.
      bus.blk_start = 1'b1;
      tick();
      bus.blk_start    = 1'b0;
      bus.init_mask_in = 32'hFFFF_FFFC;
      tick();
      check_all("dup_run", S_RUN, 32'hFFFF_FFFC, 6'd2, 1, 0, 0, 0);
      bus.wdone_valid = 1'b1;
      bus.wdone_id    = 5'd0;
      tick();
      check_all("dup_ev0", S_RUN, 32'hFFFF_FFFD, 6'd1, 1, 0, 0, 0);
      tick();
      check_all("dup_ev0b", S_RUN, 32'hFFFF_FFFD, 6'd1, 1, 0, 1, 0);
      bus.wdone_id = 5'd1;
      tick();
      check_all("dup_fin", S_DONE, 32'hFFFF_FFFF, 6'd0, 0, 1, 1, 0);
      idle_inputs();
      tick();
      check("dup_sticky", 64'(bus.err_dup), 64'(1));
      bus.wdone_valid = 1'b1;
      bus.wdone_id    = 5'd5;
      tick();
      check_all("done_spur", S_DONE, 32'hFFFF_FFFF, 6'd0, 0, 0, 1, 1);

      // Abort with a simultaneous completion event.
      idle_inputs();
      bus.blk_start = 1'b1;
      tick();
      check_all("abort_load", S_LOAD, 32'hFFFF_FFFF, 6'd0, 1, 0, 0, 0);
      bus.blk_start    = 1'b0;
      bus.init_mask_in = 32'hFFFF_0000;
      tick();
      check_all("abort_run", S_RUN, 32'hFFFF_0000, 6'd16, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         bus.wdone_valid = 1'b1;
         bus.wdone_id    = 5'(i);
         tick();
      end
      check_all("abort_pre", S_RUN, 32'hFFFF_000F, 6'd12, 1, 0, 0, 0);
      bus.blk_abort = 1'b1;
      bus.wdone_id  = 5'd4;
      tick();
      check("abort_state", 64'(bus.dbg_state), 64'(S_IDLE));
      check("abort_mask", 64'(bus.done_mask), 64'(0));
      check("abort_busy", 64'(bus.busy), 64'(0));
      check("abort_done", 64'(bus.blk_done), 64'(0));
      idle_inputs();
      tick();
      check("abort_done2", 64'(bus.blk_done), 64'(0));
      bus.wdone_valid = 1'b1;
      bus.wdone_id    = 5'd9;
      tick();
      check("idle_spur", 64'(bus.err_spurious), 64'(1));
      check("idle_mask", 64'(bus.done_mask), 64'(0));

      // Event during LOAD, blk_start in RUN, then back-to-back blocks.
      idle_inputs();
      bus.blk_start = 1'b1;
      tick();
      check("ld_spur_clr", 64'(bus.err_spurious), 64'(0));
      bus.blk_start    = 1'b0;
      bus.init_mask_in = 32'hFFFF_FFF8;
      bus.wdone_valid  = 1'b1;
      bus.wdone_id     = 5'd2;
      tick();
      check_all("ld_ev", S_RUN, 32'hFFFF_FFFC, 6'd2, 1, 0, 0, 0);
      idle_inputs();
      bus.blk_start = 1'b1;
      tick();
      check_all("run_start", S_RUN, 32'hFFFF_FFFC, 6'd2, 1, 0, 0, 1);
      idle_inputs();
      bus.wdone_valid = 1'b1;
      bus.wdone_id    = 5'd0;
      tick();
      bus.wdone_id = 5'd1;
      tick();
      check_all("b2b_fin", S_DONE, 32'hFFFF_FFFF, 6'd0, 0, 1, 0, 1);
      idle_inputs();
      bus.blk_start = 1'b1;
      tick();
      check_all("b2b_load", S_LOAD, 32'hFFFF_FFFF, 6'd0, 1, 0, 0, 0);
      bus.blk_start    = 1'b0;
      bus.init_mask_in = 32'h0000_FFFF;
      tick();
      check_all("b2b_run", S_RUN, 32'h0000_FFFF, 6'd16, 1, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
